// File: rtl/wb_result_arbiter_if.sv
// Write-back result bus: N functional-unit requesters in, one registered result out.
interface wb_result_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PREG_WIDTH = 6,
  parameter int unsigned TAG_WIDTH  = 5
);
  localparam int unsigned SRC_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_mem_addr;
  logic [NUM_REQ-1:0][PREG_WIDTH-1:0] req_preg;
  logic [NUM_REQ-1:0][TAG_WIDTH-1:0]  req_tag;
  logic [NUM_REQ-1:0]                 req_is_mem;

  logic                  wb_valid;
  logic                  wb_ready;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [DATA_WIDTH-1:0] wb_mem_addr;
  logic [PREG_WIDTH-1:0] wb_preg;
  logic [TAG_WIDTH-1:0]  wb_tag;
  logic                  wb_is_mem;
  logic [SRC_WIDTH-1:0]  wb_src;

  // Environment side: functional units plus the active-list queue.
  modport master (
    output req_valid, req_data, req_mem_addr, req_preg, req_tag, req_is_mem, wb_ready,
    input  req_ready, wb_valid, wb_data, wb_mem_addr, wb_preg, wb_tag, wb_is_mem, wb_src
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_mem_addr, req_preg, req_tag, req_is_mem, wb_ready,
    output req_ready, wb_valid, wb_data, wb_mem_addr, wb_preg, wb_tag, wb_is_mem, wb_src
  );
endinterface

// File: rtl/wb_result_arbiter.sv
// Round-robin arbiter that funnels functional-unit results into one
// registered write-back slot, with flush and backpressure stall counting.
module wb_result_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PREG_WIDTH = 6,
  parameter int unsigned TAG_WIDTH  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  wb_result_arbiter_if.slave   bus,
  output logic [15:0]          stall_count
);
  localparam int unsigned            SRC_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [SRC_WIDTH-1:0]   LAST_IDX  = SRC_WIDTH'(NUM_REQ - 1);
  localparam logic [15:0]            STALL_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [SRC_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SRC_WIDTH-1:0]  grant_idx, cand_idx;
  int unsigned           cand_sum;
  logic                  grant_found, can_accept, transfer;

  logic [DATA_WIDTH-1:0] sel_data, sel_mem_addr;
  logic [PREG_WIDTH-1:0] sel_preg;
  logic [TAG_WIDTH-1:0]  sel_tag;
  logic                  sel_is_mem;

  // Grant search from rr_ptr, ready generation and next-state logic.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_found   = 1'b0;
    grant_idx     = '0;
    cand_idx      = '0;
    cand_sum      = 0;
    transfer      = 1'b0;
    bus.req_ready = '0;

    can_accept = rst_n && !flush &&
                 ((state_q == ST_EMPTY) || ((state_q == ST_FULL) && bus.wb_ready));

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand_sum = 32'(rr_ptr_q) + i;
      if (cand_sum >= NUM_REQ) cand_sum = cand_sum - NUM_REQ;
      cand_idx = SRC_WIDTH'(cand_sum);
      if (!grant_found && bus.req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end

    transfer = can_accept && grant_found;
    if (transfer) begin
      bus.req_ready = NUM_REQ'(1) << grant_idx;
      rr_ptr_d      = (grant_idx == LAST_IDX) ? '0 : grant_idx + SRC_WIDTH'(1);
    end

    unique case (state_q)
      ST_EMPTY: if (transfer) state_d = ST_FULL;
      ST_FULL:  if (bus.wb_ready && !transfer) state_d = ST_EMPTY;
      ST_FLUSH: state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    // Flush wins over any transfer or drain and restarts the rotation.
    if (flush) begin
      state_d  = ST_FLUSH;
      rr_ptr_d = '0;
    end
  end

  // Mux the granted requester's payload.
  always_comb begin
    sel_data     = bus.req_data[grant_idx];
    sel_mem_addr = bus.req_mem_addr[grant_idx];
    sel_preg     = bus.req_preg[grant_idx];
    sel_tag      = bus.req_tag[grant_idx];
    sel_is_mem   = bus.req_is_mem[grant_idx];
  end

  // State and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Output result register; loads on every accepted transfer, holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.wb_data     <= '0;
      bus.wb_mem_addr <= '0;
      bus.wb_preg     <= '0;
      bus.wb_tag      <= '0;
      bus.wb_is_mem   <= 1'b0;
      bus.wb_src      <= '0;
    end else if (transfer) begin
      bus.wb_data     <= sel_data;
      bus.wb_mem_addr <= sel_mem_addr;
      bus.wb_preg     <= sel_preg;
      bus.wb_tag      <= sel_tag;
      bus.wb_is_mem   <= sel_is_mem;
      bus.wb_src      <= grant_idx;
    end
  end

  // Saturating count of cycles a held result is refused downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if ((state_q == ST_FULL) && !bus.wb_ready && (stall_count != STALL_MAX)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

  assign bus.wb_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_wb_result_arbiter.sv
// Bench for wb_result_arbiter: directed scenarios plus random traffic,
// all checked against a transaction-level model of the write-back slot.
module tb_wb_result_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = 6;
  localparam int unsigned TW = 5;
  localparam int unsigned SW = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] stall_count;

  wb_result_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .PREG_WIDTH(PW), .TAG_WIDTH(TW)) bus ();

  wb_result_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .PREG_WIDTH(PW), .TAG_WIDTH(TW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model of the slot: is a result held, are we in the flush bubble,
  // where the rotation starts, and what the held result is.
  bit            m_full     = 1'b0;
  bit            m_flushing = 1'b0;
  int            m_ptr      = 0;
  int            m_stall    = 0;
  logic [DW-1:0] m_data     = '0;
  logic [DW-1:0] m_addr     = '0;
  logic [PW-1:0] m_preg     = '0;
  logic [TW-1:0] m_tag      = '0;
  logic          m_is_mem   = 1'b0;
  int            m_src      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which requester the slot takes this cycle, or -1.
  function automatic int exp_grant();
    if (!rst_n || flush || m_flushing || (m_full && !bus.wb_ready)) return -1;
    for (int k = 0; k < int'(N); k++) begin
      int idx;
      idx = (m_ptr + k) % int'(N);
      if (bus.req_valid[SW'(idx)]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    g = exp_grant();
    if (g < 0) return '0;
    return N'(1) << g;
  endfunction

  // Model advance on each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_full = 1'b0; m_flushing = 1'b0; m_ptr = 0; m_stall = 0;
        m_data = '0; m_addr = '0; m_preg = '0; m_tag = '0; m_is_mem = 1'b0; m_src = 0;
      end else begin
        int g;
        g = exp_grant();
        if (m_full && !bus.wb_ready && m_stall < 65535) m_stall++;
        if (flush) begin
          m_flushing = 1'b1;
          m_full     = 1'b0;
          m_ptr      = 0;
        end else if (m_flushing) begin
          m_flushing = 1'b0;
        end else if (g >= 0) begin
          m_full   = 1'b1;
          m_data   = bus.req_data[SW'(g)];
          m_addr   = bus.req_mem_addr[SW'(g)];
          m_preg   = bus.req_preg[SW'(g)];
          m_tag    = bus.req_tag[SW'(g)];
          m_is_mem = bus.req_is_mem[SW'(g)];
          m_src    = g;
          m_ptr    = (g + 1) % int'(N);
        end else if (m_full && bus.wb_ready) begin
          m_full = 1'b0;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("req_ready",   64'(bus.req_ready),   64'(exp_ready()));
        chk("wb_valid",    64'(bus.wb_valid),    64'(m_full));
        chk("wb_data",     64'(bus.wb_data),     64'(m_data));
        chk("wb_mem_addr", 64'(bus.wb_mem_addr), 64'(m_addr));
        chk("wb_preg",     64'(bus.wb_preg),     64'(m_preg));
        chk("wb_tag",      64'(bus.wb_tag),      64'(m_tag));
        chk("wb_is_mem",   64'(bus.wb_is_mem),   64'(m_is_mem));
        chk("wb_src",      64'(bus.wb_src),      64'(m_src));
        chk("stall_count", 64'(stall_count),     64'(m_stall));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #2;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < int'(N); i++) begin
      bus.req_data[i]     = DW'($urandom);
      bus.req_mem_addr[i] = DW'($urandom);
      bus.req_preg[i]     = PW'($urandom);
      bus.req_tag[i]      = TW'($urandom);
      bus.req_is_mem[i]   = 1'($urandom);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; bus.wb_ready = 1'b0; bus.req_valid = 4'hF;
    rand_fields();
    cyc();
    chk_en = 1'b1;
    cyc();

    // Reset state, with requests present.
    at_neg();
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_stall",    64'(stall_count),  64'd0);
    chk("rst_wb_tag",   64'(bus.wb_tag),   64'd0);
    chk("rst_ready",    64'(bus.req_ready), 64'd0);

    // Single request from requester 2.
    cyc();
    rst_n = 1'b1; bus.req_valid = 4'b0100; bus.req_tag[2] = 5'd7; bus.wb_ready = 1'b1;
    at_neg();
    chk("single_ready", 64'(bus.req_ready), 64'b0100);
    cyc();
    bus.req_valid = 4'b0000;
    at_neg();
    chk("single_wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("single_wb_tag",   64'(bus.wb_tag),   64'd7);
    chk("single_wb_src",   64'(bus.wb_src),   64'd2);
    chk("single_model_ptr", 64'(m_ptr),       64'd3);

    // Drain, then flush so the rotation restarts at 0.
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();

    // Fairness: all requesters valid, grants rotate with no bubble.
    bus.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk("fair_ready", 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
      if (k > 0) begin
        chk("fair_wb_valid", 64'(bus.wb_valid), 64'd1);
        chk("fair_wb_src",   64'(bus.wb_src),   64'(k - 1));
      end
      cyc();
      rand_fields();
    end

    // Backpressure: result from requester 0 is held for 5 cycles.
    bus.wb_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk("bp_ready", 64'(bus.req_ready), 64'd0);
      chk("bp_src",   64'(bus.wb_src),    64'd0);
      chk("bp_stall", 64'(stall_count),   64'(k));
      cyc();
    end
    bus.wb_ready = 1'b1;
    at_neg();
    chk("bp_release_stall", 64'(stall_count),   64'd5);
    chk("bp_release_ready", 64'(bus.req_ready), 64'b0010);
    cyc();
    bus.wb_ready = 1'b0; bus.req_valid = 4'h0;
    at_neg();
    chk("bp_next_src",   64'(bus.wb_src),   64'd1);
    chk("bp_next_valid", 64'(bus.wb_valid), 64'd1);

    // Flush while a result is held under backpressure.
    cyc();
    flush = 1'b1; bus.req_valid = 4'hF;
    at_neg();
    chk("flush_ready", 64'(bus.req_ready), 64'd0);
    cyc();
    flush = 1'b0;
    at_neg();
    chk("flush_wb_valid", 64'(bus.wb_valid),  64'd0);
    chk("flush_ready2",   64'(bus.req_ready), 64'd0);
    chk("flush_model_ptr", 64'(m_ptr),        64'd0);

    // Flush coinciding with requests and drain readiness.
    cyc();
    flush = 1'b1; bus.wb_ready = 1'b1;
    at_neg();
    chk("simul_ready", 64'(bus.req_ready), 64'd0);
    cyc();
    flush = 1'b0;
    at_neg();
    chk("simul_wb_valid", 64'(bus.wb_valid),  64'd0);
    chk("simul_ready2",   64'(bus.req_ready), 64'd0);
    cyc();
    at_neg();
    chk("post_flush_ready", 64'(bus.req_ready), 64'b0001);

    // Reset in the middle of a stall.
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; bus.req_valid = 4'b0001; bus.wb_ready = 1'b1;
    cyc();
    bus.req_valid = 4'h0; bus.wb_ready = 1'b0;
    repeat (3) cyc();
    at_neg();
    chk("mid_stall",    64'(stall_count),  64'd3);
    chk("mid_wb_valid", 64'(bus.wb_valid), 64'd1);
    rst_n = 1'b0; flush = 1'b1; bus.req_valid = 4'hF;
    cyc();
    at_neg();
    chk("mid_rst_wb_valid", 64'(bus.wb_valid),  64'd0);
    chk("mid_rst_stall",    64'(stall_count),   64'd0);
    chk("mid_rst_wb_tag",   64'(bus.wb_tag),    64'd0);
    chk("mid_rst_ready",    64'(bus.req_ready), 64'd0);
    cyc();
    rst_n = 1'b1; flush = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rand_fields();
      bus.req_valid = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      bus.wb_ready  = ($urandom_range(0, 9) < 7);
      flush         = ($urandom_range(0, 39) == 0);
      rst_n         = ($urandom_range(0, 149) != 0);
      cyc();
    end

    at_neg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_result_arbiter.md
WB_RESULT_ARBITER -- requirements
Module: wb_result_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of functional-unit requesters; DATA_WIDTH, default 32, result/address width; PREG_WIDTH, default 6, physical register index width; TAG_WIDTH, default 5, active-list tag width.
REQ-002 Ports SHALL be:
- clk  input  1  sole clock; all state updates on posedge
- rst_n  input  1  synchronous active-low reset
- flush  input  1  pipeline flush from hazard control
- req_valid  input  NUM_REQ  per-requester result valid
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
- req_data  input  NUM_REQ x DATA_WIDTH  result data
- req_mem_addr  input  NUM_REQ x DATA_WIDTH  store address
- req_preg  input  NUM_REQ x PREG_WIDTH  destination physical register
- req_tag  input  NUM_REQ x TAG_WIDTH  active-list tag
- req_is_mem  input  NUM_REQ  1 = memory result, 0 = register result
- wb_valid  output  1  output register holds a result
- wb_ready  input  1  active-list queue accepts the result
- wb_data, wb_mem_addr  output  DATA_WIDTH each  registered result fields
- wb_preg  output  PREG_WIDTH  registered destination register
- wb_tag  output  TAG_WIDTH  registered tag
- wb_is_mem  output  1  registered memory/register flag
- wb_src  output  clog2(NUM_REQ)  index of the requester that produced wb_*
- stall_count  output  16  saturating count of backpressure cycles

Function
REQ-003 The FSM SHALL have states EMPTY (wb_valid=0), FULL (wb_valid=1) and FLUSH, with wb_valid decoded from state.
REQ-004 In EMPTY, or in FULL with wb_ready=1, and flush=0, the block SHALL be able to accept; otherwise all req_ready SHALL be 0.
REQ-005 When able to accept and any req_valid=1, the grant SHALL be the first valid requester at or after rr_ptr in ascending index order, wrapping modulo NUM_REQ; req_ready SHALL be combinational and asserted for the granted index only.
REQ-006 A transfer occurs when req_valid[g] and req_ready[g] are both 1; the granted fields SHALL appear on wb_* with wb_src=g on the next cycle, giving 1-cycle latency.
REQ-007 On each transfer, rr_ptr SHALL become (g+1) mod NUM_REQ; with no transfer, rr_ptr SHALL hold.
REQ-008 Transitions SHALL be:
- EMPTY->FULL on transfer
- FULL->FULL on drain plus transfer in the same cycle, or on wb_ready=0
- FULL->EMPTY on drain with no transfer
REQ-009 Sustained throughput SHALL be one result per cycle while wb_ready=1 and any requester is valid.
REQ-010 While FULL and wb_ready=0, wb_* SHALL hold stable; stall_count SHALL increment by 1 each such cycle and saturate at 16'hFFFF.
REQ-011 When flush=1 in any state, the next state SHALL be FLUSH, req_ready SHALL be 0 that cycle, and any held result SHALL be discarded without a handshake.
REQ-012 FLUSH SHALL last exactly one cycle, with wb_valid=0 and req_ready=0, then go to EMPTY; flush=1 while in FLUSH SHALL extend FLUSH by one cycle.
REQ-013 On flush, rr_ptr SHALL reset to 0; stall_count SHALL be unaffected.
REQ-014 flush SHALL take priority over transfer and drain in the same cycle.
REQ-015 For NUM_REQ that is not a power of two, the rr_ptr wrap SHALL use explicit compare-to-(NUM_REQ-1), not bit truncation.

Reset
REQ-016 When rst_n=0 at a posedge, the block SHALL set state=EMPTY, rr_ptr=0, stall_count=0, and wb_data/wb_mem_addr/wb_preg/wb_tag/wb_is_mem/wb_src=0; req_ready SHALL be 0 while rst_n=0.
REQ-017 Reset SHALL override flush and any in-progress transfer; the first accept is possible on the first cycle with rst_n=1.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Single request: reset, then req_valid=4'b0100 with tag=5'd7 and wb_ready=1 -> req_ready=4'b0100 the same cycle; next cycle wb_valid=1, wb_tag=7, wb_src=2; rr_ptr=3.
- Fairness: all four requesters held valid with wb_ready=1 -> grant order 0,1,2,3,0 on consecutive cycles, with no idle cycle.
- Backpressure: FULL with wb_ready=0 for 5 cycles -> wb_* stable, req_ready=0, stall_count=5; on the wb_ready=1 cycle a new grant is issued and wb_* updates on the next cycle.
- Flush: FULL with wb_ready=0 and flush pulsed -> next cycle FLUSH with wb_valid=0 and req_ready=0; then EMPTY; rr_ptr=0; the held result is never handshaken.
- Simultaneous events: flush=1 and req_valid=4'b1111 with wb_ready=1 in the same cycle -> no req_ready asserted, no transfer, state FLUSH.
- Reset mid-stream: rst_n=0 while FULL with stall_count=3 -> next cycle wb_valid=0, stall_count=0, wb_tag=0.
